voice_allocator: RTL

- Polyphony controller for the oscillator bank: accepts note-on/note-off requests, assigns each to one of NUM_VOICES oscillator slots, and drives each slot's enable/freq/amplitude/shape.
- Applies a linear attack/release amplitude ramp per voice on the sample tick.
- Steals the oldest voice when all slots are busy.
- Sits between the MIDI/command decoder and the oscillator instances.

---
 rtl/voice_allocator.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphony controller for the oscillator bank.
// Accepts note-on/note-off requests, picks an oscillator slot for each one, and
// drives every slot's enable, frequency word, amplitude and waveform. Amplitudes
// follow a linear attack/release ramp that advances on sample_tick. When every
// slot is busy, the oldest sounding voice is stolen.
//
// Each request is resolved by a SCAN pass that visits one voice per cycle,
// followed by a single COMMIT cycle. The result reaches the outputs
// NUM_VOICES+1 cycles after the request is accepted.
//
// Waveform encoding (2 bits): 0 sawtooth, 1 sine, 2 square, 3 triangle.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   sample_tick       one-cycle pulse per audio sample, advances the ramps
//   note_valid/ready  request handshake; ready is high only when idle
//   note_on           1 = note-on, 0 = note-off
//   note_key          key number used for matching
//   note_freq/amp/
//   note_shape        oscillator settings, used by note-on only
//   voice_enable      bit i enables oscillator i
//   voice_freq        voice i at [16i+15:16i]
//   voice_amplitude   voice i at [WIDTH*i+WIDTH-1:WIDTH*i]
//   voice_shape       voice i at [2i+1:2i]
//   busy              a request is being processed
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned RAMP_STEP  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic                        note_valid,
  output logic                        note_ready,
  input  logic                        note_on,
  input  logic [6:0]                  note_key,
  input  logic [15:0]                 note_freq,
  input  logic [WIDTH-1:0]            note_amp,
  input  logic [1:0]                  note_shape,
  output logic [NUM_VOICES-1:0]       voice_enable,
  output logic [16*NUM_VOICES-1:0]    voice_freq,
  output logic [WIDTH*NUM_VOICES-1:0] voice_amplitude,
  output logic [2*NUM_VOICES-1:0]     voice_shape,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);
  localparam int unsigned ExtW = WIDTH + 1;
  localparam logic [ExtW-1:0]  StepExt = ExtW'(RAMP_STEP);
  localparam logic [WIDTH-1:0] Step    = WIDTH'(RAMP_STEP);
  localparam logic [1:0]       ShapeSawtooth = 2'd0;

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;
  typedef enum logic [1:0] {VoiceOff, VoiceAttack, VoiceSustain, VoiceRelease} vstate_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] scan_idx_q, scan_idx_d;

  // Latched request
  logic             req_on_q;
  logic [6:0]       req_key_q;
  logic [15:0]      req_freq_q;
  logic [WIDTH-1:0] req_amp_q;
  logic [1:0]       req_shape_q;

  // Scan results
  logic            match_found_q, match_found_d;
  logic [IdxW-1:0] match_idx_q, match_idx_d;
  logic            free_found_q, free_found_d;
  logic [IdxW-1:0] free_idx_q, free_idx_d;
  logic            old_found_q, old_found_d;
  logic [IdxW-1:0] old_idx_q, old_idx_d;
  logic [7:0]      old_age_q, old_age_d;

  // Per-voice state
  vstate_e          v_state_q [NUM_VOICES];
  vstate_e          v_state_d [NUM_VOICES];
  logic [WIDTH-1:0] v_amp_q   [NUM_VOICES];
  logic [WIDTH-1:0] v_amp_d   [NUM_VOICES];
  logic [WIDTH-1:0] v_tgt_q   [NUM_VOICES];
  logic [WIDTH-1:0] v_tgt_d   [NUM_VOICES];
  logic [15:0]      v_freq_q  [NUM_VOICES];
  logic [15:0]      v_freq_d  [NUM_VOICES];
  logic [1:0]       v_shape_q [NUM_VOICES];
  logic [1:0]       v_shape_d [NUM_VOICES];
  logic [7:0]       v_age_q   [NUM_VOICES];
  logic [7:0]       v_age_d   [NUM_VOICES];
  logic [6:0]       v_key_q   [NUM_VOICES];
  logic [6:0]       v_key_d   [NUM_VOICES];

  logic            xfer;
  logic            commit_on, commit_off, commit_hit;
  logic [IdxW-1:0] commit_idx;

  assign note_ready = (state_q == StIdle);
  assign busy       = ~note_ready;
  assign xfer       = note_valid & note_ready;

  // Control FSM and scan bookkeeping
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    unique case (state_q)
      StIdle: begin
        if (note_valid) begin
          state_d       = StScan;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          old_age_d     = '0;
        end
      end
      StScan: begin
        if (v_state_q[scan_idx_q] != VoiceOff) begin
          if (!match_found_q && (v_key_q[scan_idx_q] == req_key_q)) begin
            match_found_d = 1'b1;
            match_idx_d   = scan_idx_q;
          end
          // Strict compare keeps the lowest index on equal ages
          if (!old_found_q || (v_age_q[scan_idx_q] > old_age_q)) begin
            old_found_d = 1'b1;
            old_idx_d   = scan_idx_q;
            old_age_d   = v_age_q[scan_idx_q];
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (scan_idx_q == IdxW'(NUM_VOICES - 1)) begin
          state_d = StCommit;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Commit target: key match, else free slot, else oldest (which may have gone
  // OFF during the scan and is still a legal target).
  always_comb begin
    commit_on  = (state_q == StCommit) && req_on_q;
    commit_off = (state_q == StCommit) && !req_on_q && match_found_q &&
                 ((v_state_q[match_idx_q] == VoiceAttack) ||
                  (v_state_q[match_idx_q] == VoiceSustain));
    commit_hit = commit_on | commit_off;
    if (!commit_on || match_found_q) commit_idx = match_idx_q;
    else if (free_found_q)           commit_idx = free_idx_q;
    else                             commit_idx = old_idx_q;
  end

  // Per-voice next state: commit update wins over the ramp on the same cycle
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      v_state_d[i] = v_state_q[i];
      v_amp_d[i]   = v_amp_q[i];
      v_tgt_d[i]   = v_tgt_q[i];
      v_freq_d[i]  = v_freq_q[i];
      v_shape_d[i] = v_shape_q[i];
      v_age_d[i]   = v_age_q[i];
      v_key_d[i]   = v_key_q[i];
      if (commit_hit && (commit_idx == IdxW'(i))) begin
        if (commit_on) begin
          v_state_d[i] = VoiceAttack;
          v_amp_d[i]   = match_found_q ? v_amp_q[i] : '0;
          v_tgt_d[i]   = req_amp_q;
          v_freq_d[i]  = req_freq_q;
          v_shape_d[i] = req_shape_q;
          v_key_d[i]   = req_key_q;
          v_age_d[i]   = '0;
        end else begin
          v_state_d[i] = VoiceRelease;
        end
      end else begin
        if (commit_on && (v_state_q[i] != VoiceOff) && (v_age_q[i] != 8'hFF)) begin
          v_age_d[i] = v_age_q[i] + 8'd1;
        end
        if (sample_tick) begin
          case (v_state_q[i])
            VoiceAttack: begin
              if (({1'b0, v_amp_q[i]} + StepExt) >= {1'b0, v_tgt_q[i]}) begin
                v_amp_d[i]   = v_tgt_q[i];
                v_state_d[i] = VoiceSustain;
              end else begin
                v_amp_d[i] = v_amp_q[i] + Step;
              end
            end
            VoiceRelease: begin
              if ({1'b0, v_amp_q[i]} <= StepExt) begin
                v_amp_d[i]   = '0;
                v_state_d[i] = VoiceOff;
              end else begin
                v_amp_d[i] = v_amp_q[i] - Step;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      scan_idx_q    <= '0;
      req_on_q      <= 1'b0;
      req_key_q     <= '0;
      req_freq_q    <= '0;
      req_amp_q     <= '0;
      req_shape_q   <= ShapeSawtooth;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_state_q[i] <= VoiceOff;
        v_amp_q[i]   <= '0;
        v_tgt_q[i]   <= '0;
        v_freq_q[i]  <= '0;
        v_shape_q[i] <= ShapeSawtooth;
        v_age_q[i]   <= '0;
        v_key_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      if (xfer) begin
        req_on_q    <= note_on;
        req_key_q   <= note_key;
        req_freq_q  <= note_freq;
        req_amp_q   <= note_amp;
        req_shape_q <= note_shape;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_state_q[i] <= v_state_d[i];
        v_amp_q[i]   <= v_amp_d[i];
        v_tgt_q[i]   <= v_tgt_d[i];
        v_freq_q[i]  <= v_freq_d[i];
        v_shape_q[i] <= v_shape_d[i];
        v_age_q[i]   <= v_age_d[i];
        v_key_q[i]   <= v_key_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_enable[i]                  = (v_state_q[i] != VoiceOff);
      voice_freq[16*i +: 16]           = v_freq_q[i];
      voice_amplitude[WIDTH*i +: WIDTH] = v_amp_q[i];
      voice_shape[2*i +: 2]            = v_shape_q[i];
    end
  end

endmodule
